// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters (ALU, load unit), the issue-stage
// reservation port and the regfile write port.
interface regfile_wb_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic                  req_valid0;
  logic                  req_ready0;
  logic [ADDR_WIDTH-1:0] req_addr0;
  logic [DATA_WIDTH-1:0] req_data0;
  logic                  req_valid1;
  logic                  req_ready1;
  logic [ADDR_WIDTH-1:0] req_addr1;
  logic [DATA_WIDTH-1:0] req_data1;
  logic                  reserve;
  logic [ADDR_WIDTH-1:0] reserve_addr;
  logic [NUM_REGS-1:0]   busy;
  logic [ADDR_WIDTH-1:0] write_register;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  reg_write;

  modport slave (
    input  req_valid0, req_addr0, req_data0,
    input  req_valid1, req_addr1, req_data1,
    input  reserve, reserve_addr,
    output req_ready0, req_ready1, busy,
    output write_register, write_data, reg_write
  );

  modport master (
    output req_valid0, req_addr0, req_data0,
    output req_valid1, req_addr1, req_data1,
    output reserve, reserve_addr,
    input  req_ready0, req_ready1, busy,
    input  write_register, write_data, reg_write
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port between ALU (0) and load
// unit (1), with a busy scoreboard of destination registers awaiting writeback.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  bus
);
  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic                  last_grant;
  logic                  grant0;
  logic                  grant1;
  logic [NUM_REGS-1:0]   busy_q;
  logic [NUM_REGS-1:0]   busy_nxt;
  logic [NUM_REGS-1:0]   clr_mask;
  logic [NUM_REGS-1:0]   set_mask;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic [DATA_WIDTH-1:0] gnt_data;

  // On a tie the requester that did not win last time goes; readys are
  // suppressed while reset is asserted.
  always_comb begin
    grant0 = rst_n && bus.req_valid0 && (!bus.req_valid1 || last_grant);
    grant1 = rst_n && bus.req_valid1 && (!bus.req_valid0 || !last_grant);
  end

  assign bus.req_ready0 = grant0;
  assign bus.req_ready1 = grant1;

  always_comb begin
    gnt_addr = grant1 ? bus.req_addr1 : bus.req_addr0;
    gnt_data = grant1 ? bus.req_data1 : bus.req_data0;
  end

  // Reserve is applied after the clear so a same-edge reserve wins; r0 never busy.
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (grant0 || grant1) clr_mask[gnt_addr] = 1'b1;
    if (bus.reserve) set_mask[bus.reserve_addr] = 1'b1;
    busy_nxt    = (busy_q & ~clr_mask) | set_mask;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      busy_q     <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
    end else begin
      busy_q <= busy_nxt;
      if (grant0 || grant1) begin
        last_grant <= grant1;
        wr_addr_q  <= gnt_addr;
        wr_data_q  <= gnt_data;
        wr_en_q    <= (gnt_addr != '0);
      end else begin
        wr_en_q <= 1'b0;
      end
    end
  end

  assign bus.busy           = busy_q;
  assign bus.write_register = wr_addr_q;
  assign bus.write_data     = wr_data_q;
  assign bus.reg_write      = wr_en_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: vector table for single-cycle steps,
// hand-written sequences for reset corner cases, behavioral regfile for read-back.
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  regfile_wb_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] rf [32] = '{default: 32'd0};
  always @(posedge clk) begin
    if (bus.reg_write) rf[bus.write_register] <= bus.write_data;
  end

  typedef struct {
    logic        v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        rsv;
    logic [4:0]  ra;
    logic        r0;
    logic        r1;
    logic        we;
    logic        chk_wd;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] busy;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  function automatic vec_t mk(logic v0, logic [4:0] a0, logic [31:0] d0,
                              logic v1, logic [4:0] a1, logic [31:0] d1,
                              logic rsv, logic [4:0] ra,
                              logic r0, logic r1, logic we, logic chk_wd,
                              logic [4:0] wa, logic [31:0] wd, logic [31:0] busy);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.rsv = rsv; v.ra = ra;
    v.r0 = r0; v.r1 = r1; v.we = we; v.chk_wd = chk_wd;
    v.wa = wa; v.wd = wd; v.busy = busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.req_valid0 = 1'b0; bus.req_addr0 = '0; bus.req_data0 = '0;
    bus.req_valid1 = 1'b0; bus.req_addr1 = '0; bus.req_data1 = '0;
    bus.reserve = 1'b0; bus.reserve_addr = '0;
  endtask

  initial begin
    //            v0 a0  d0   v1 a1  d1   rsv ra  r0 r1 we cw wa  wd   busy
    vecs[0]  = mk(1, 2,  42,  1, 3,  15,  0, 0,   1, 0, 1, 1, 2,  42,  32'h0);
    vecs[1]  = mk(0, 0,  0,   1, 3,  15,  0, 0,   0, 1, 1, 1, 3,  15,  32'h0);
    vecs[2]  = mk(1, 4,  10,  1, 5,  20,  0, 0,   1, 0, 1, 1, 4,  10,  32'h0);
    vecs[3]  = mk(1, 4,  11,  1, 5,  20,  0, 0,   0, 1, 1, 1, 5,  20,  32'h0);
    vecs[4]  = mk(1, 4,  11,  1, 6,  30,  0, 0,   1, 0, 1, 1, 4,  11,  32'h0);
    vecs[5]  = mk(1, 4,  12,  1, 6,  30,  0, 0,   0, 1, 1, 1, 6,  30,  32'h0);
    vecs[6]  = mk(1, 4,  12,  1, 5,  21,  0, 0,   1, 0, 1, 1, 4,  12,  32'h0);
    vecs[7]  = mk(1, 8,  1,   1, 5,  21,  0, 0,   0, 1, 1, 1, 5,  21,  32'h0);
    vecs[8]  = mk(0, 0,  0,   0, 0,  0,   0, 0,   0, 0, 0, 1, 5,  21,  32'h0);
    vecs[9]  = mk(1, 0,  3,   0, 0,  0,   0, 0,   1, 0, 0, 0, 0,  0,   32'h0);
    vecs[10] = mk(0, 0,  0,   0, 0,  0,   1, 0,   0, 0, 0, 0, 0,  0,   32'h0);
    vecs[11] = mk(0, 0,  0,   0, 0,  0,   1, 7,   0, 0, 0, 0, 0,  0,   32'h80);
    vecs[12] = mk(0, 0,  0,   1, 7,  99,  0, 0,   0, 1, 1, 1, 7,  99,  32'h0);
    vecs[13] = mk(0, 0,  0,   0, 0,  0,   1, 7,   0, 0, 0, 1, 7,  99,  32'h80);
    vecs[14] = mk(0, 0,  0,   1, 7,  100, 1, 7,   0, 1, 1, 1, 7,  100, 32'h80);
    vecs[15] = mk(0, 0,  0,   1, 9,  1,   0, 0,   0, 1, 1, 1, 9,  1,   32'h80);
    vecs[16] = mk(0, 0,  0,   1, 9,  2,   0, 0,   0, 1, 1, 1, 9,  2,   32'h80);
    vecs[17] = mk(0, 0,  0,   1, 9,  3,   0, 0,   0, 1, 1, 1, 9,  3,   32'h80);
    vecs[18] = mk(1, 10, 50,  1, 11, 60,  0, 0,   1, 0, 1, 1, 10, 50,  32'h80);
    vecs[19] = mk(0, 0,  0,   1, 11, 60,  0, 0,   0, 1, 1, 1, 11, 60,  32'h80);

    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.req_valid0 = 1'b1;
    bus.req_valid1 = 1'b1;
    #1;
    chk("rst_ready0", {31'd0, bus.req_ready0}, 32'd0);
    chk("rst_ready1", {31'd0, bus.req_ready1}, 32'd0);
    chk("rst_regwrite", {31'd0, bus.reg_write}, 32'd0);
    chk("rst_waddr", {27'd0, bus.write_register}, 32'd0);
    chk("rst_wdata", bus.write_data, 32'd0);
    chk("rst_busy", bus.busy, 32'd0);
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      bus.req_valid0 = vecs[i].v0; bus.req_addr0 = vecs[i].a0; bus.req_data0 = vecs[i].d0;
      bus.req_valid1 = vecs[i].v1; bus.req_addr1 = vecs[i].a1; bus.req_data1 = vecs[i].d1;
      bus.reserve = vecs[i].rsv; bus.reserve_addr = vecs[i].ra;
      #1;
      chk($sformatf("v%0d_ready0", i), {31'd0, bus.req_ready0}, {31'd0, vecs[i].r0});
      chk($sformatf("v%0d_ready1", i), {31'd0, bus.req_ready1}, {31'd0, vecs[i].r1});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_regwrite", i), {31'd0, bus.reg_write}, {31'd0, vecs[i].we});
      if (vecs[i].chk_wd) begin
        chk($sformatf("v%0d_waddr", i), {27'd0, bus.write_register}, {27'd0, vecs[i].wa});
        chk($sformatf("v%0d_wdata", i), bus.write_data, vecs[i].wd);
      end
      chk($sformatf("v%0d_busy", i), bus.busy, vecs[i].busy);
    end

    @(negedge clk);
    drive_idle();
    @(negedge clk);
    chk("rf_r0", rf[0], 32'd0);
    chk("rf_r2", rf[2], 32'd42);
    chk("rf_r3", rf[3], 32'd15);
    chk("rf_r4", rf[4], 32'd12);
    chk("rf_r5", rf[5], 32'd21);
    chk("rf_r6", rf[6], 32'd30);
    chk("rf_r7", rf[7], 32'd100);
    chk("rf_r9", rf[9], 32'd3);
    chk("rf_r10", rf[10], 32'd50);
    chk("rf_r11", rf[11], 32'd60);

    // Reset between grant and commit: last grant was R1, so R0 wins this tie.
    bus.req_valid0 = 1'b1; bus.req_addr0 = 5'd12; bus.req_data0 = 32'd77;
    bus.req_valid1 = 1'b1; bus.req_addr1 = 5'd13; bus.req_data1 = 32'd88;
    @(posedge clk);
    #1;
    drive_idle();
    chk("mid_regwrite_pre", {31'd0, bus.reg_write}, 32'd1);
    chk("mid_waddr_pre", {27'd0, bus.write_register}, 32'd12);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_regwrite_rst", {31'd0, bus.reg_write}, 32'd0);
    chk("mid_busy_rst", bus.busy, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("mid_rf_r12", rf[12], 32'd0);
    rst_n = 1'b1;
    bus.req_valid0 = 1'b1; bus.req_addr0 = 5'd13; bus.req_data0 = 32'd5;
    bus.req_valid1 = 1'b1; bus.req_addr1 = 5'd14; bus.req_data1 = 32'd6;
    #1;
    chk("post_rst_ready0", {31'd0, bus.req_ready0}, 32'd1);
    chk("post_rst_ready1", {31'd0, bus.req_ready1}, 32'd0);
    @(posedge clk);
    #1;
    chk("post_rst_waddr", {27'd0, bus.write_register}, 32'd13);
    chk("post_rst_wdata", bus.write_data, 32'd5);
    drive_idle();
    @(posedge clk);
    #1;
    chk("post_rst_rf_r13", rf[13], 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
